// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns an enumerated operation plus register, immediate
// and target fields into 32-bit MIPS32 instruction words. Each word leaves
// through one registered stage with a valid/ready handshake and carries its
// byte address. LI is expanded into lui + ori.
// Optional build macro: MIPS_ENC_DELAY_SLOT_EN. When it is defined, a
// 0x00000000 delay-slot word follows every branch or jump word.
module mips_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic [15:0] word_count,
    output logic        err_illegal
);

`ifdef MIPS_ENC_DELAY_SLOT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_LI2 = 2'd2, ST_SLOT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_LI2 = 2'd2} state_t;
`endif

    state_t      state_r;
    logic [4:0]  li_rt_r;
    logic [15:0] li_imm_r;
    logic [31:0] enc_word_s;
    logic        accept_s;
    logic        handshake_s;
    logic        legal_s;
    logic        is_li_s;
    logic        is_branch_s;

    function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                           input logic [4:0] f_rd, input logic [4:0] f_sh,
                                           input logic [5:0] f_fn);
        return {6'h00, f_rs, f_rt, f_rd, f_sh, f_fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] f_op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [15:0] f_imm);
        return {f_op, f_rs, f_rt, f_imm};
    endfunction

    // Operation fields a given instruction does not use are replaced by zero here.
    function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [4:0] f_rd,
                                           input logic [4:0] f_sh, input logic [31:0] f_imm,
                                           input logic [25:0] f_tgt);
        logic [31:0] w;
        case (op)
            6'd0:  w = r_word(5'd0, f_rt, f_rd, f_sh, 6'h00);  // sll
            6'd1:  w = r_word(5'd0, f_rt, f_rd, f_sh, 6'h02);  // srl
            6'd2:  w = r_word(5'd0, f_rt, f_rd, f_sh, 6'h03);  // sra
            6'd3:  w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h04);  // sllv
            6'd4:  w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h06);  // srlv
            6'd5:  w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h07);  // srav
            6'd6:  w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h20);  // add
            6'd7:  w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h21);  // addu
            6'd8:  w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h22);  // sub
            6'd9:  w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h23);  // subu
            6'd10: w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h24);  // and
            6'd11: w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h25);  // or
            6'd12: w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h26);  // xor
            6'd13: w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h27);  // nor
            6'd14: w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h2A);  // slt
            6'd15: w = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h2B);  // sltu
            6'd16: w = r_word(f_rs, 5'd0, 5'd0, 5'd0, 6'h08);  // jr
            6'd17: w = r_word(f_rs, 5'd0, f_rd, 5'd0, 6'h09);  // jalr
            6'd18: w = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h18);  // mult
            6'd19: w = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h19);  // multu
            6'd20: w = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h1A);  // div
            6'd21: w = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h1B);  // divu
            6'd22: w = r_word(5'd0, 5'd0, f_rd, 5'd0, 6'h10);  // mfhi
            6'd23: w = r_word(5'd0, 5'd0, f_rd, 5'd0, 6'h12);  // mflo
            6'd24: w = r_word(f_rs, 5'd0, 5'd0, 5'd0, 6'h11);  // mthi
            6'd25: w = r_word(f_rs, 5'd0, 5'd0, 5'd0, 6'h13);  // mtlo
            6'd26: w = i_word(6'h08, f_rs, f_rt, f_imm[15:0]); // addi
            6'd27: w = i_word(6'h09, f_rs, f_rt, f_imm[15:0]); // addiu
            6'd28: w = i_word(6'h0C, f_rs, f_rt, f_imm[15:0]); // andi
            6'd29: w = i_word(6'h0D, f_rs, f_rt, f_imm[15:0]); // ori
            6'd30: w = i_word(6'h0E, f_rs, f_rt, f_imm[15:0]); // xori
            6'd31: w = i_word(6'h0F, 5'd0, f_rt, f_imm[15:0]); // lui
            6'd32: w = i_word(6'h0A, f_rs, f_rt, f_imm[15:0]); // slti
            6'd33: w = i_word(6'h0B, f_rs, f_rt, f_imm[15:0]); // sltiu
            6'd34: w = i_word(6'h20, f_rs, f_rt, f_imm[15:0]); // lb
            6'd35: w = i_word(6'h24, f_rs, f_rt, f_imm[15:0]); // lbu
            6'd36: w = i_word(6'h21, f_rs, f_rt, f_imm[15:0]); // lh
            6'd37: w = i_word(6'h25, f_rs, f_rt, f_imm[15:0]); // lhu
            6'd38: w = i_word(6'h23, f_rs, f_rt, f_imm[15:0]); // lw
            6'd39: w = i_word(6'h28, f_rs, f_rt, f_imm[15:0]); // sb
            6'd40: w = i_word(6'h29, f_rs, f_rt, f_imm[15:0]); // sh
            6'd41: w = i_word(6'h2B, f_rs, f_rt, f_imm[15:0]); // sw
            6'd42: w = i_word(6'h04, f_rs, f_rt, f_imm[15:0]); // beq
            6'd43: w = i_word(6'h05, f_rs, f_rt, f_imm[15:0]); // bne
            6'd44: w = i_word(6'h06, f_rs, 5'd0, f_imm[15:0]); // blez
            6'd45: w = i_word(6'h01, f_rs, 5'd0, f_imm[15:0]); // bltz (REGIMM rt=0)
            6'd46: w = i_word(6'h01, f_rs, 5'd1, f_imm[15:0]); // bgez (REGIMM rt=1)
            6'd47: w = i_word(6'h07, f_rs, 5'd0, f_imm[15:0]); // bgtz
            6'd48: w = {6'h02, f_tgt};                         // j
            6'd49: w = {6'h03, f_tgt};                         // jal
            6'd50: w = {6'h10, 5'h00, f_rt, f_rd, 11'd0};      // mfc0
            6'd51: w = {6'h10, 5'h04, f_rt, f_rd, 11'd0};      // mtc0
            6'd52: w = 32'h4200_0018;                          // eret
            6'd53: w = i_word(6'h0F, 5'd0, f_rt, f_imm[31:16]); // LI first half: lui
            6'd54: w = 32'h0000_0000;                          // NOP
            default: w = 32'h0000_0000;                        // illegal, never emitted
        endcase
        return w;
    endfunction

    assign in_ready    = (state_r == ST_IDLE) && (!out_valid || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign handshake_s = out_valid && out_ready;
    assign legal_s     = (op_sel <= 6'd54);
    assign is_li_s     = (op_sel == 6'd53);
    assign is_branch_s = (op_sel == 6'd16) || (op_sel == 6'd17) ||
                         ((op_sel >= 6'd42) && (op_sel <= 6'd49));

    // Encode the currently presented request.
    always_comb begin
        enc_word_s = encode(op_sel, rs, rt, rd, shamt, imm, target);
    end

    // Address and consumed-word counter advance on every output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_addr   <= BASE_ADDR;
            word_count <= 16'd0;
        end else if (handshake_s) begin
            out_addr   <= out_addr + ADDR_STEP;
            word_count <= word_count + 16'd1;
        end else begin
            out_addr   <= out_addr;
            word_count <= word_count;
        end
    end

    // Control FSM and output word register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0000_0000;
            err_illegal <= 1'b0;
            li_rt_r     <= 5'd0;
            li_imm_r    <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (!legal_s) begin
                            // Request is consumed but produces no word.
                            err_illegal <= 1'b1;
                            out_valid   <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            out_instr <= enc_word_s;
                            if (is_li_s) begin
                                state_r  <= ST_LI2;
                                li_rt_r  <= rt;
                                li_imm_r <= imm[15:0];
`ifdef MIPS_ENC_DELAY_SLOT_EN
                            end else if (is_branch_s) begin
                                state_r <= ST_SLOT;
`endif
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end
                    end else if (handshake_s) begin
                        out_valid <= 1'b0;
                    end else if (out_valid) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // Word is stalled; it stays untouched until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_LI2: begin
                    // Second half of LI replaces the lui word once it is taken.
                    if (out_ready) begin
                        out_instr <= {6'h0D, li_rt_r, li_rt_r, li_imm_r};
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_LI2;
                    end
                end
`ifdef MIPS_ENC_DELAY_SLOT_EN
                ST_SLOT: begin
                    if (out_ready) begin
                        out_instr <= 32'h0000_0000;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_SLOT;
                    end
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the instruction decoder: takes an enumerated operation plus register, immediate and target fields, and emits 32-bit MIPS instruction words with a target byte address.
- Used by the self-test loader to write programs into instruction memory, and by the bench to generate stimulus.
- Expands the LI pseudo-op into two words. Output is a single registered stage with a valid/ready handshake.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of the first emitted word; also the out_addr reset value.
- ADDR_STEP, 4, out_addr increment per accepted word.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- op_sel  in  6  operation code; enumeration in Behaviour.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- imm  in  32  [15:0] for I-type and branch; full 32 bits for LI.
- target  in  26  j/jal instr_index.
- out_valid  out  1  out_instr and out_addr valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded word.
- out_addr  out  32  byte address of out_instr.
- word_count  out  16  number of words accepted by the consumer; wraps.
- err_illegal  out  1  sticky; set when an illegal op_sel is accepted.

Behaviour:
- **op_sel enumeration:**
  - 0-5: sll, srl, sra, sllv, srlv, srav
  - 6-15: add, addu, sub, subu, and, or, xor, nor, slt, sltu
  - 16-25: jr, jalr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo
  - 26-33: addi, addiu, andi, ori, xori, lui, slti, sltiu
  - 34-41: lb, lbu, lh, lhu, lw, sb, sh, sw
  - 42-47: beq, bne, blez, bltz, bgez, bgtz
  - 48-49: j, jal
  - 50-52: mfc0, mtc0, eret
  - 53: LI (pseudo)
  - 54: NOP
  - 55-63: illegal
- **Field encoding:** standard MIPS32 opcode and funct values. Fields an instruction does not use are forced to 0, whatever the inputs carry:
  - sll/srl/sra: rs=0.
  - mult/div family: rd=0, shamt=0.
  - mfhi/mflo: rd only.
  - mthi/mtlo/jr: rs only.
  - jalr: rs and rd.
  - lui: rs=0.
  - blez/bgtz/bltz: rt=0; bgez: rt=1 (opcode 000001 for bltz/bgez).
  - mfc0: 0x40000000 | rt<<16 | rd<<11.
  - mtc0: 0x40800000 | rt<<16 | rd<<11.
  - eret: 0x42000018.
  - NOP: 0x00000000.
- **FSM states:** IDLE, HOLD, LI2.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept (in_valid && in_ready), legal op: out_instr/out_valid loaded next cycle (latency 1).
  - LI accept: first word is lui rt, imm[31:16]. The FSM goes to LI2 holding rt and imm[15:0]. When the first word is accepted, the second word ori rt, rt, imm[15:0] is loaded and the FSM returns to IDLE.
  - HOLD covers a stalled word: out_instr and out_addr stay stable while out_valid && !out_ready. Back-to-back throughput is 1 word/cycle when out_ready=1.
- **Address and count:** out_addr and word_count advance by ADDR_STEP and 1 respectively on each out_valid && out_ready handshake. out_addr wraps modulo 2^32.
- **Illegal op:** the request is accepted (consumed) but no word is emitted. err_illegal sets and stays set until reset; out_addr is unchanged.
- **Reset:** asynchronous, any state including mid-LI; the pending second word is discarded. Reset values:
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, word_count=0, err_illegal=0, state=IDLE.
  - in_ready=1 after reset deasserts.

Optional Feature:
- Macro MIPS_ENC_DELAY_SLOT_EN.
- Defined: after any branch/jump word (ops 16, 17, 42-49), the encoder automatically emits a 0x00000000 delay-slot word at the next address via an extra state SLOT. in_ready stays low until the NOP is accepted.
- Undefined: no insertion; the SLOT state is absent.

Test Plan:
- addu rd=3 rs=1 rt=2, out_ready=1 -> out_instr=0x00221821 at 0x3000 one cycle later; word_count=1.
- ori rt=8 rs=0 imm=0x1234 with garbage in rd/shamt -> 0x34081234; unused fields zero.
- LI rt=4 imm=0xDEADBEEF -> 0x3C04DEAD at 0x3000, then 0x3484BEEF at 0x3004; in_ready low until the second word is accepted.
- bltz rs=5 imm=0xFFFF with out_ready held low 3 cycles -> 0x04A0FFFF stable throughout; address advances only on the handshake.
- op_sel=60 -> no out_valid, err_illegal=1 sticky, out_addr unchanged. Assert reset mid-LI -> all outputs at reset values and the second word is never emitted.
- With MIPS_ENC_DELAY_SLOT_EN: beq rs=1 rt=2 imm=3 -> 0x10220003 then 0x00000000 at +4. Without the macro, the next request's word follows directly.
